// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The loader state is exported so checkers can bind to it directly.
package inst_loader_pkg;

  localparam int INST_W = 9;
  localparam int MAX_WORDS = 1024;
  localparam int LEN_W = 11;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    WAIT_SYNC = 3'd0,
    LEN_LO    = 3'd1,
    LEN_HI    = 3'd2,
    INST_LO   = 3'd3,
    INST_HI   = 3'd4,
    CHECK     = 3'd5,
    DONE      = 3'd6,
    ERROR     = 3'd7
  } loader_state_t;

endpackage

// File: rtl/inst_loader.sv
// Framed byte-stream loader for the 9-bit instruction memory; keeps the core
// in reset until a full, checksum-verified program has been written.
module inst_loader
  import inst_loader_pkg::loader_state_t, inst_loader_pkg::SYNC_BYTE_DEFAULT,
         inst_loader_pkg::MAX_WORDS, inst_loader_pkg::LEN_W,
         inst_loader_pkg::WAIT_SYNC, inst_loader_pkg::LEN_LO, inst_loader_pkg::LEN_HI,
         inst_loader_pkg::INST_LO, inst_loader_pkg::INST_HI, inst_loader_pkg::CHECK,
         inst_loader_pkg::DONE, inst_loader_pkg::ERROR;
#(
  parameter int         ADDR_W    = 10,
  parameter int         INST_W    = 9,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Restart,
  input  logic              InValid,
  input  logic [7:0]        InData,
  output logic              InReady,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [INST_W-1:0] WrData,
  output logic              CpuHold,
  output logic              Done,
  output logic              Error,
  output logic [ADDR_W:0]   WordCount,
  output loader_state_t     DbgState
);

  // Handshake: a byte moves on a rising edge where InValid & InReady are both
  // high. InReady drops combinationally under Restart so an offered byte is
  // never consumed in the abort cycle.

  loader_state_t     r_state;
  logic              r_in_ready;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [INST_W-1:0] r_wr_data;
  logic              r_hold;
  logic              r_done;
  logic              r_error;
  logic [ADDR_W:0]   r_cnt;
  logic [LEN_W-1:0]  r_len;
  logic [7:0]        r_len_lo;
  logic [7:0]        r_lo;
  logic [7:0]        r_xor;

  logic              w_xfer;
  logic [LEN_W-1:0]  w_len;
  logic              w_len_bad;
  logic [ADDR_W:0]   w_cnt_inc;
  logic              w_last_word;

  assign InReady     = r_in_ready & ~Restart;
  assign w_xfer      = InValid & InReady;
  assign w_len       = {InData[2:0], r_len_lo};
  assign w_len_bad   = (|InData[7:3]) || (w_len == '0) || (w_len > LEN_W'(MAX_WORDS));
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_last_word = (LEN_W'(w_cnt_inc) == r_len);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= WAIT_SYNC;
      r_in_ready <= 1'b1;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_hold     <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_len_lo   <= '0;
      r_lo       <= '0;
      r_xor      <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (Restart) begin
        r_state    <= WAIT_SYNC;
        r_in_ready <= 1'b1;
        r_hold     <= 1'b1;
        r_done     <= 1'b0;
        r_error    <= 1'b0;
        r_cnt      <= '0;
      end else if (w_xfer) begin
        case (r_state)
          WAIT_SYNC: if (InData == SYNC_BYTE) r_state <= LEN_LO;
          LEN_LO: begin
            r_len_lo <= InData;
            r_state  <= LEN_HI;
          end
          LEN_HI: begin
            if (w_len_bad) begin
              r_state <= ERROR;
              r_error <= 1'b1;
            end else begin
              r_len   <= w_len;
              r_cnt   <= '0;
              r_xor   <= '0;
              r_state <= INST_LO;
            end
          end
          INST_LO: begin
            r_lo    <= InData;
            r_xor   <= r_xor ^ InData;
            r_state <= INST_HI;
          end
          INST_HI: begin
            // Only bit 0 of the high byte is instruction data.
            if (|InData[7:1]) begin
              r_state <= ERROR;
              r_error <= 1'b1;
            end else begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_cnt[ADDR_W-1:0];
              r_wr_data <= {InData[0], r_lo};
              r_cnt     <= w_cnt_inc;
              r_xor     <= r_xor ^ InData;
              r_state   <= w_last_word ? CHECK : INST_LO;
            end
          end
          CHECK: begin
            if (InData == r_xor) begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_hold     <= 1'b0;
              r_in_ready <= 1'b0;
            end else begin
              r_state <= ERROR;
              r_error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign WrEn      = r_wr_en;
  assign WrAddr    = r_wr_addr;
  assign WrData    = r_wr_data;
  assign CpuHold   = r_hold;
  assign Done      = r_done;
  assign Error     = r_error;
  assign WordCount = r_cnt;
  assign DbgState  = r_state;

endmodule
